fifo_wr_arbiter: RTL and testbench

Round-robin write arbiter that shares the write port of one synchronous FIFO between NUM_REQ independent producers. Each producer presents words on a valid/ready handshake. The arbiter grants one producer at a time for a bounded burst and drives the FIFO's wr_en/data_in, never writing while the FIFO reports full. It sits directly in front of the FIFO write side; the FIFO's read side is untouched.

---
 rtl/fifo_arb_pkg.sv | 18 +
 rtl/rr_pick.sv | 38 +++
 rtl/fifo_wr_arbiter.sv | 118 +++++++++++
 tb/tb_fifo_wr_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Purpose: shared types and helpers for the FIFO write-port round-robin arbiter.
// Latency: n/a (types and a pure combinational helper only).
// Backpressure: n/a.
// Contents: arb_state_t (IDLE/BURST FSM encoding), next_index() wrapped increment.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    // Increment idx, wrapping from n-1 back to 0. Works for any n >= 1,
    // including non-power-of-2 producer counts.
    function automatic int next_index(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Purpose: rotating-priority picker; first set request at or after base, wrapping.
// Latency: purely combinational.
// Backpressure: none; evaluates every cycle.
// Ports: req_i    - request vector, one bit per producer
//        base_i   - index with highest priority this evaluation
//        any_o    - at least one request bit is set
//        idx_o    - chosen index (0 when any_o=0)
module rr_pick #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic [$clog2(NUM_REQ)-1:0] base_i,
    output logic                       any_o,
    output logic [$clog2(NUM_REQ)-1:0] idx_o
);

    localparam int IW = $clog2(NUM_REQ);

    // Walk offsets from farthest to nearest so the nearest set bit
    // (smallest rotation distance from base) is the last one written.
    always_comb begin : pick
        int j;
        j     = 0;
        any_o = 1'b0;
        idx_o = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            j = int'(base_i) + k;
            if (j >= NUM_REQ) begin
                j = j - NUM_REQ;
            end
            if (req_i[IW'(j)]) begin
                any_o = 1'b1;
                idx_o = IW'(j);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Purpose: round-robin arbiter sharing one FIFO write port among NUM_REQ producers.
// Latency: one IDLE cycle per grant for arbitration; data passes combinationally in BURST.
// Backpressure: fifo_full holds the grant (no transfer, stall=1, no re-arbitration).
// Ports: clk/rst (sync, active-low); req_valid/req_data/req_ready per-producer
//        handshake lanes; fifo_full/fifo_wr_en/fifo_data_in FIFO write side;
//        grant_active/grant_id/stall grant status.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int NUM_REQ   = 4,
    parameter int BURST_MAX = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic                       fifo_full,
    output logic                       fifo_wr_en,
    output logic [WIDTH-1:0]           fifo_data_in,
    output logic                       grant_active,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       stall
);

    localparam int IDW  = $clog2(NUM_REQ);
    localparam int CNTW = $clog2(BURST_MAX + 1);

    arb_state_t      state_q, state_d;
    logic [IDW-1:0]  grant_id_q, grant_id_d;
    logic [CNTW-1:0] burst_cnt_q, burst_cnt_d;
    logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;

    logic            pick_any;
    logic [IDW-1:0]  pick_idx;
    logic            in_burst;
    logic            gnt_vld;
    logic            xfer;
    logic            last_word;
    logic [WIDTH-1:0] lane [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
        assign lane[i] = req_data[i*WIDTH +: WIDTH];
    end

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req_i  (req_valid),
        .base_i (rr_ptr_q),
        .any_o  (pick_any),
        .idx_o  (pick_idx)
    );

    assign in_burst  = (state_q == BURST);
    assign gnt_vld   = req_valid[grant_id_q];
    // Writes are also gated by rst so a word presented in the reset cycle
    // is never committed to the FIFO.
    assign xfer      = in_burst && gnt_vld && !fifo_full && rst;
    assign last_word = (burst_cnt_q == CNTW'(BURST_MAX - 1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            grant_id_q  <= '0;
            burst_cnt_q <= '0;
            rr_ptr_q    <= '0;
        end else begin
            state_q     <= state_d;
            grant_id_q  <= grant_id_d;
            burst_cnt_q <= burst_cnt_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_id_d  = grant_id_q;
        burst_cnt_d = burst_cnt_q;
        rr_ptr_d    = rr_ptr_q;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    grant_id_d  = pick_idx;
                    burst_cnt_d = '0;
                    state_d     = BURST;
                end
            end
            BURST: begin
                // Leaving on a dropped valid covers both a finished producer
                // and one that withdrew an unaccepted word.
                if (!gnt_vld || (xfer && last_word)) begin
                    state_d     = IDLE;
                    burst_cnt_d = '0;
                    rr_ptr_d    = IDW'(next_index(int'(grant_id_q), NUM_REQ));
                end else if (xfer) begin
                    burst_cnt_d = burst_cnt_q + CNTW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        if (in_burst && !fifo_full && rst) begin
            req_ready[grant_id_q] = 1'b1;
        end
    end

    assign fifo_wr_en   = xfer;
    assign fifo_data_in = lane[grant_id_q];
    assign grant_active = in_burst;
    assign grant_id     = grant_id_q;
    assign stall        = in_burst && gnt_vld && fifo_full;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Purpose: self-checking bench for fifo_wr_arbiter (4-producer and 3-producer instances).
// Latency: expectations pushed per cycle by the driver, popped by negedge monitors.
// Backpressure: fifo_full driven by directed scenarios and randomly.
module tb_fifo_wr_arbiter;

    localparam int N = 4;
    localparam int W = 8;
    localparam int B = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT A: 4 producers ----------------
    logic           rst;
    logic [N-1:0]   valid;
    logic [N*W-1:0] data;
    logic [N-1:0]   ready;
    logic           full;
    logic           wr;
    logic [W-1:0]   din;
    logic           act;
    logic [1:0]     gid;
    logic           stall;
    logic [W-1:0]   pdata [N];

    assign data = {pdata[3], pdata[2], pdata[1], pdata[0]};

    fifo_wr_arbiter #(.WIDTH(W), .NUM_REQ(N), .BURST_MAX(B)) dut_a (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (valid),
        .req_data     (data),
        .req_ready    (ready),
        .fifo_full    (full),
        .fifo_wr_en   (wr),
        .fifo_data_in (din),
        .grant_active (act),
        .grant_id     (gid),
        .stall        (stall)
    );

    // ---------------- DUT B: 3 producers ----------------
    logic        b_rst;
    logic [2:0]  b_valid;
    logic [23:0] b_data;
    logic [2:0]  b_ready;
    logic        b_full;
    logic        b_wr;
    logic [7:0]  b_din;
    logic        b_act;
    logic [1:0]  b_gid;
    logic        b_stall;

    assign b_data = {8'hC2, 8'hB1, 8'hA0};
    assign b_full = 1'b0;

    fifo_wr_arbiter #(.WIDTH(8), .NUM_REQ(3), .BURST_MAX(4)) dut_b (
        .clk          (clk),
        .rst          (b_rst),
        .req_valid    (b_valid),
        .req_data     (b_data),
        .req_ready    (b_ready),
        .fifo_full    (b_full),
        .fifo_wr_en   (b_wr),
        .fifo_data_in (b_din),
        .grant_active (b_act),
        .grant_id     (b_gid),
        .stall        (b_stall)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] a, input logic [31:0] x);
        checks++;
        if (a !== x) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, a, x, $time);
        end
    endtask

    // ---------------- reference model (A) ----------------
    typedef struct {
        logic         wr;
        logic [W-1:0] din;
        logic [N-1:0] rdy;
        logic         act;
        logic [1:0]   gid;
        logic         stall;
    } exp_t;

    exp_t expq [$];
    bit   chk_en = 1'b0;

    bit           m_busy = 1'b0; // a producer holds the grant
    int           m_who  = 0;    // granted producer
    int           m_left = 0;    // words still allowed in this grant
    int           m_next = 0;    // producer with first claim at the next arbitration
    logic [N-1:0] acc    = '0;   // producers whose word was consumed last cycle

    function automatic exp_t predict();
        exp_t e;
        e.act   = m_busy;
        e.gid   = 2'(m_who);
        e.din   = pdata[m_who];
        e.rdy   = '0;
        e.wr    = 1'b0;
        e.stall = 1'b0;
        if (m_busy) begin
            e.stall = valid[m_who] && full;
            if (!full && rst) begin
                e.rdy = N'(1 << m_who);
                e.wr  = valid[m_who];
            end
        end
        return e;
    endfunction

    task automatic advance(input exp_t e);
        int found;
        if (!rst) begin
            m_busy = 1'b0;
            m_who  = 0;
            m_next = 0;
        end else if (!m_busy) begin
            found = -1;
            for (int k = 0; k < N; k++) begin
                if (found < 0 && valid[(m_next + k) % N]) found = (m_next + k) % N;
            end
            if (found >= 0) begin
                m_busy = 1'b1;
                m_who  = found;
                m_left = B;
            end
        end else begin
            if (e.wr) m_left = m_left - 1;
            if (!valid[m_who] || (e.wr && m_left == 0)) begin
                m_busy = 1'b0;
                m_next = (m_who + 1) % N;
            end
        end
    endtask

    task automatic cycle();
        exp_t e;
        e = predict();
        expq.push_back(e);
        @(posedge clk);
        #1;
        advance(e);
        acc = e.rdy & valid;
        for (int i = 0; i < N; i++) begin
            if (acc[i]) pdata[i] = pdata[i] + 8'd1;
        end
    endtask

    task automatic do_reset();
        rst   = 1'b0;
        valid = '0;
        full  = 1'b0;
        cycle();
        rst   = 1'b1;
    endtask

    // ---------------- monitor A ----------------
    exp_t me;
    always @(negedge clk) begin
        if (chk_en) begin
            if (expq.size() == 0) begin
                chk("scoreboard_underflow", 32'd1, 32'd0);
            end else begin
                me = expq.pop_front();
                chk("fifo_wr_en", wr, me.wr);
                chk("req_ready", ready, me.rdy);
                chk("grant_active", act, me.act);
                chk("stall", stall, me.stall);
                chk("grant_id", gid, me.gid);
                if (me.wr) chk("fifo_data_in", din, me.din);
                chk("ready_at_most_one", ($countones(ready) <= 1), 1);
                chk("no_write_when_full", (wr && full), 0);
            end
        end
    end

    // ---------------- monitor B: grant order and burst length ----------------
    int   gq [$];
    bit   bchk       = 1'b0;
    logic b_prev_act = 1'b0;
    int   bcur       = 0;
    int   bwords     = 0;
    int   bdone      = 0;

    function automatic logic [7:0] blane(input int i);
        case (i)
            0:       return 8'hA0;
            1:       return 8'hB1;
            default: return 8'hC2;
        endcase
    endfunction

    always @(negedge clk) begin
        if (bchk) begin
            if (b_act && !b_prev_act) begin
                if (gq.size() == 0) begin
                    chk("b_extra_grant", 32'(b_gid), 32'hFF);
                end else begin
                    bcur = gq.pop_front();
                    chk("b_grant_id", b_gid, bcur);
                end
                bwords = 0;
            end
            if (b_wr) begin
                bwords++;
                chk("b_data", b_din, blane(bcur));
            end
            if (!b_act && b_prev_act) begin
                chk("b_burst_len", bwords, 4);
                bdone++;
            end
            b_prev_act = b_act;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rst     = 1'b0;
        valid   = '0;
        full    = 1'b0;
        b_rst   = 1'b0;
        b_valid = 3'b110;
        for (int i = 0; i < N; i++) pdata[i] = 8'(8'h40 * i);
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;

        // Reset state, then single producer 2 streaming 0x10..0x17.
        do_reset();
        pdata[2] = 8'h10;
        valid    = 4'b0100;
        for (int c = 0; c < 30 && pdata[2] != 8'h18; c++) cycle();
        valid = '0;
        cycle();

        // All producers valid continuously: grants rotate 0,1,2,3,0.
        do_reset();
        valid = 4'b1111;
        repeat (26) cycle();
        valid = '0;
        cycle();

        // Back-pressure: producer 1, full for 5 cycles after 2 words.
        do_reset();
        pdata[1] = 8'h20;
        valid    = 4'b0010;
        for (int c = 0; c < 10 && pdata[1] != 8'h22; c++) cycle();
        full = 1'b1;
        repeat (5) cycle();
        full = 1'b0;
        for (int c = 0; c < 10 && pdata[1] != 8'h24; c++) cycle();
        valid = '0;
        repeat (2) cycle();

        // Early drop: producer 0 leaves after 1 word, producer 3 is next.
        do_reset();
        pdata[0] = 8'h30;
        pdata[3] = 8'h60;
        valid    = 4'b1001;
        for (int c = 0; c < 10 && pdata[0] != 8'h31; c++) cycle();
        valid[0] = 1'b0;
        repeat (8) cycle();
        valid = '0;
        cycle();

        // Reset during the second word of a burst.
        do_reset();
        valid = 4'b1111;
        repeat (2) cycle();
        rst = 1'b0;
        cycle();
        rst = 1'b1;
        repeat (8) cycle();
        valid = '0;
        cycle();

        // Randomised traffic with back-pressure, drops and occasional reset.
        do_reset();
        for (int c = 0; c < 800; c++) begin
            rst  = ($urandom_range(0, 149) != 0);
            full = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < N; i++) begin
                if (acc[i])        valid[i] = ($urandom_range(0, 3) != 0);
                else if (valid[i]) valid[i] = ($urandom_range(0, 19) != 0);
                else               valid[i] = ($urandom_range(0, 2) == 0);
            end
            cycle();
        end
        rst   = 1'b1;
        valid = '0;
        full  = 1'b0;
        repeat (2) cycle();
        chk_en = 1'b0;
        chk("scoreboard_drained", expq.size(), 0);

        // Three producers, only 1 and 2 requesting: grants 1,2,1,2.
        gq.push_back(1);
        gq.push_back(2);
        gq.push_back(1);
        gq.push_back(2);
        b_rst = 1'b1;
        bchk  = 1'b1;
        for (int c = 0; c < 60; c++) begin
            @(posedge clk);
            #1;
            if (gq.size() == 0 && bdone >= 4) break;
        end
        bchk = 1'b0;
        chk("b_grants_seen", gq.size(), 0);
        chk("b_bursts_done", bdone, 4);
        b_rst   = 1'b0;
        b_valid = '0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
